// File: rtl/sync_tx_pkg.sv
// Shared types for the sync_tx_arbiter slice: FSM state encoding and counter sizing.
package sync_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_ACK_LOW = 2'd3
    } sync_tx_state_t;

    // Phase counter must reach max(en, hold) without wrapping.
    function automatic int cnt_width(input int en, input int hold);
        int m;
        m = (en > hold) ? en : hold;
        return ($clog2(m + 1) > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot pick searching from the slot after the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] gnt_next
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;
    logic          found;
    int            j;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        gnt_next = '0;
        win_idx  = ptr;
        found    = 1'b0;
        j        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found       = 1'b1;
                gnt_next[j] = 1'b1;
                win_idx     = IW'(j);
            end
        end
    end

    // Pointer starts at the last index so requester 0 wins first after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= IW'(NUM_REQ - 1);
        else if (update)
            ptr <= win_idx;
    end

endmodule

// File: rtl/sync_tx_arbiter.sv
// Source-side sequencer sharing one data_sync crossing between NUM_REQ requesters.
// Define SYNC_TX_ACK_EN for the four-phase ack_sync handshake instead of fixed timing.
module sync_tx_arbiter
    import sync_tx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
`ifdef SYNC_TX_ACK_EN
    input  logic                         ack_sync,
`endif
    output logic [NUM_REQ-1:0]           grant,
    output logic [BUS_WIDTH-1:0]         Unsync_bus,
    output logic                         bus_enable,
    output logic                         busy
);

    localparam int CW = cnt_width(EN_CYCLES, HOLD_CYCLES);

    sync_tx_state_t       state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [NUM_REQ-1:0]   gnt_next;
    logic [BUS_WIDTH-1:0] word;
    logic                 capture;
    logic                 be_next;
    logic                 ack_hi;

`ifdef SYNC_TX_ACK_EN
    assign ack_hi = ack_sync;
`else
    assign ack_hi = 1'b0;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .update   (capture),
        .gnt_next (gnt_next)
    );

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt_next[k]) word = word | req_data[k*BUS_WIDTH +: BUS_WIDTH];
    end

    // A capture also waits for a stale ack to fall; ack_hi is tied low without the handshake.
    assign capture = (state == ST_IDLE) && (|req) && !ack_hi;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (capture) state_next = ST_LAUNCH;
            end
`ifdef SYNC_TX_ACK_EN
            ST_LAUNCH:  if (ack_hi)  state_next = ST_ACK_LOW;
            ST_ACK_LOW: if (!ack_hi) state_next = ST_IDLE;
`else
            ST_LAUNCH: if (cnt == CW'(EN_CYCLES - 1)) begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
            ST_HOLD: if (cnt == CW'(HOLD_CYCLES - 1)) state_next = ST_IDLE;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        be_next = 1'b0;
        case (state)
            ST_IDLE:   be_next = capture;
`ifdef SYNC_TX_ACK_EN
            ST_LAUNCH: be_next = !ack_hi;
`else
            ST_LAUNCH: be_next = (cnt != CW'(EN_CYCLES - 1));
`endif
            default:   be_next = 1'b0;
        endcase
    end

    // Outputs are registered so data_sync sees a glitch-free enable edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= '0;
            Unsync_bus <= '0;
            bus_enable <= 1'b0;
        end else begin
            grant      <= capture ? gnt_next : '0;
            bus_enable <= be_next;
            if (capture) Unsync_bus <= word;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed self-checking bench for sync_tx_arbiter (default parameters).
module tb_sync_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        ack_sync;
    logic [3:0]  grant;
    logic [7:0]  Unsync_bus;
    logic        bus_enable;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    sync_tx_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
`ifdef SYNC_TX_ACK_EN
        .ack_sync   (ack_sync),
`endif
        .grant      (grant),
        .Unsync_bus (Unsync_bus),
        .bus_enable (bus_enable),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
        ack_sync = 1'b0;
        repeat (2) tick();
        check("rst_grant", grant, 0);
        check("rst_bus", Unsync_bus, 0);
        check("rst_be", bus_enable, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

`ifdef SYNC_TX_ACK_EN
        req = 4'b0001;
        tick();
        check("ack_grant", grant, 4'b0001);
        check("ack_be1", bus_enable, 1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("ack_be_hi", bus_enable, 1);
        end
        ack_sync = 1'b1;
        tick();
        check("ack_be_lo", bus_enable, 0);
        check("ack_busy", busy, 1);
        tick();
        tick();
        ack_sync = 1'b0;
        check("ack_wait_grant", grant, 0);
        check("ack_wait_busy", busy, 1);
        tick();
        check("ack_idle", busy, 0);
        tick();
        check("ack_regrant", grant, 4'b0001);
        check("ack_rebe", bus_enable, 1);
`else
        // Single word from requester 0.
        req = 4'b0001;
        tick();
        check("t1_grant", grant, 4'b0001);
        check("t1_be1", bus_enable, 1);
        check("t1_bus", Unsync_bus, 8'hA5);
        check("t1_busy", busy, 1);
        req = 4'b0000;
        tick();
        check("t1_grant_c2", grant, 0);
        check("t1_be_c2", bus_enable, 1);
        for (int c = 3; c <= 6; c++) begin
            tick();
            check("t1_be_low", bus_enable, 0);
            check("t1_hold_busy", busy, 1);
            check("t1_hold_bus", Unsync_bus, 8'hA5);
        end
        tick();
        check("t1_idle_busy", busy, 0);
        tick();
        check("t1_stay_idle", busy, 0);
        check("t1_keep_bus", Unsync_bus, 8'hA5);

        // All requesters held: rotate 0,1,2,3,0 every 7 cycles.
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        req      = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_grant", grant, 32'(4'b0001 << (g % 4)));
            check("rr_bus", Unsync_bus, 32'h10 + 32'(g % 4));
            for (int c = 0; c < 6; c++) begin
                tick();
                check("rr_gap", grant, 0);
            end
            check("rr_idle", busy, 0);
        end
        tick();

        // Grant 2, then 0101 must wrap to 0.
        req = 4'b0100;
        repeat (7) tick();
        check("wrap_g2", grant, 4'b0100);
        req = 4'b0101;
        repeat (7) tick();
        check("wrap_g0", grant, 4'b0001);

        // Reset during HOLD of 3C; pending req re-granted after release.
        req      = 4'b1000;
        req_data = {8'h3C, 8'h12, 8'h11, 8'h10};
        repeat (7) tick();
        check("rst_mid_grant", grant, 4'b1000);
        check("rst_mid_bus", Unsync_bus, 8'h3C);
        repeat (2) tick();
        check("rst_mid_hold", bus_enable, 0);
        check("rst_mid_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async_bus", Unsync_bus, 0);
        check("async_busy", busy, 0);
        check("async_be", bus_enable, 0);
        check("async_grant", grant, 0);
        tick();
        reset = 1'b1;
        tick();
        check("rearb_grant", grant, 4'b1000);
        check("rearb_bus", Unsync_bus, 8'h3C);

        // Requester 1 drops before the decision cycle and must not win.
        req = 4'b0110;
        repeat (5) tick();
        req = 4'b0100;
        repeat (2) tick();
        check("drop_grant", grant, 4'b0100);
        check("drop_onehot", 32'($onehot(grant)), 1);
        check("drop_bus", Unsync_bus, 8'h12);
        req = 4'b0000;
        tick();
        check("drop_pulse", grant, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
